// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the PicoRV32 trace capture buffer.
package trace_capture_pkg;

  localparam int TRACE_W = 36;
  localparam logic [3:0]  MARKER_TAG = 4'hF;
  localparam logic [15:0] MARKER_SIG = 16'hDEAD;

  typedef enum logic [1:0] {
    CAPTURE  = 2'd0,
    DROPPING = 2'd1,
    FROZEN   = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/trace_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head word.
// A word pushed into an otherwise empty FIFO is presented on out_data right after its push edge.
module trace_sync_fifo #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 36
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_next;
  logic [LVL_W-1:0]  remaining, level_next;
  logic              do_push, do_pop;

  always_comb begin
    do_push    = push && (level != LVL_W'(DEPTH));
    do_pop     = pop && out_valid;
    remaining  = level - LVL_W'(do_pop);
    level_next = remaining + LVL_W'(do_push);
    rd_next    = rd_ptr + PTR_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Head is refilled from storage, or straight from the push when nothing else is queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_ptr    <= rd_next;
      wr_ptr    <= wr_ptr + PTR_W'(do_push);
      level     <= level_next;
      out_valid <= (level_next != '0);
      if (remaining != '0)
        out_data <= mem[rd_next];
      else if (do_push)
        out_data <= push_data;
    end
  end

endmodule

// File: rtl/trace_capture_fifo.sv
// Trace capture buffer: FIFO, drop accounting and trap freeze for the PicoRV32 trace port.
// Define TRACE_DROP_MARKER_EN to insert drop-marker words (4'hF, 16'hDEAD, count) after overflow.
module trace_capture_fifo
  import trace_capture_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = TRACE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_valid,
  input  logic [DATA_W-1:0]          trace_data,
  input  logic                       trap,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                drop_total,
  output logic                       frozen
);

  localparam int LVL_W = $clog2(DEPTH+1);

  state_t            state, state_next;
  logic              push, drop, full;
  logic [DATA_W-1:0] push_data;
`ifdef TRACE_DROP_MARKER_EN
  logic [15:0]       pending, pending_next;
  logic [DATA_W-1:0] marker;
  assign marker = {MARKER_TAG, MARKER_SIG, pending};
`endif

  // Full looks only at the registered level, so a same-cycle pop never frees a slot.
  assign full   = (level == LVL_W'(DEPTH));
  assign frozen = (state == FROZEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CAPTURE;
      drop_total <= 16'd0;
`ifdef TRACE_DROP_MARKER_EN
      pending    <= 16'd0;
`endif
    end else begin
      state <= state_next;
      if (drop) drop_total <= sat_inc16(drop_total);
`ifdef TRACE_DROP_MARKER_EN
      pending <= pending_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
`ifdef TRACE_DROP_MARKER_EN
    pending_next = pending;
`endif
    case (state)
      CAPTURE: begin
`ifdef TRACE_DROP_MARKER_EN
        if (trace_valid && full) begin
          state_next   = DROPPING;
          pending_next = 16'd1;
        end
`endif
      end
      DROPPING: begin
`ifdef TRACE_DROP_MARKER_EN
        if (!full) begin
          if (trace_valid) begin
            pending_next = 16'd1;
          end else begin
            pending_next = 16'd0;
            state_next   = CAPTURE;
          end
        end else if (trace_valid) begin
          pending_next = sat_inc16(pending);
        end
`else
        state_next = CAPTURE;
`endif
      end
      FROZEN: begin
`ifdef TRACE_DROP_MARKER_EN
        if (pending != 16'd0 && !full) pending_next = 16'd0;
`endif
      end
      default: state_next = CAPTURE;
    endcase
    // A trap wins over every other transition; only reset leaves FROZEN.
    if (trap) state_next = FROZEN;
  end

  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    push_data = trace_data;
    case (state)
      CAPTURE: begin
        if (trace_valid) begin
          if (full) drop = 1'b1;
          else      push = 1'b1;
        end
      end
      DROPPING: begin
        drop = trace_valid;
`ifdef TRACE_DROP_MARKER_EN
        if (!full) begin
          push      = 1'b1;
          push_data = marker;
        end
`endif
      end
      FROZEN: begin
        drop = trace_valid;
`ifdef TRACE_DROP_MARKER_EN
        if (pending != 16'd0 && !full) begin
          push      = 1'b1;
          push_data = marker;
        end
`endif
      end
      default: ;
    endcase
  end

  trace_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level)
  );

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Directed self-checking bench for trace_capture_fifo at DEPTH=4.
// Runs the drop-marker scenario instead of plain overflow when TRACE_DROP_MARKER_EN is defined.
module tb_trace_capture_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_valid;
  logic [35:0] trace_data;
  logic        trap;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_data;
  logic [2:0]  level;
  logic [15:0] drop_total;
  logic        frozen;

  int errors = 0;
  int checks = 0;

  trace_capture_fifo #(.DEPTH(4), .DATA_W(36)) dut (
    .clk         (clk),
    .reset       (reset),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .trap        (trap),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .drop_total  (drop_total),
    .frozen      (frozen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    trace_valid = 1'b0; trace_data = '0; trap = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    trace_valid = 1'b0; trace_data = '0; trap = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d expected 0", level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (out_data !== 36'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h expected 0", out_data); end
    checks++; if (drop_total !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop_total got %0d expected 0", drop_total); end
    checks++; if (frozen !== 1'b0) begin errors++; $display("[TB] FAIL reset_frozen got %b expected 0", frozen); end
  endtask

  task automatic test_write_drain();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      trace_valid = 1'b1; trace_data = 36'(i);
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 36'(i)) begin errors++; $display("[TB] FAIL wd_head%0d got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 36'(i)); end
      checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL wd_level%0d got %0d expected 1", i, level); end
    end
    trace_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("[TB] FAIL wd_empty got v=%b level=%0d expected v=0 level=0", out_valid, level); end
    checks++; if (drop_total !== 16'd0) begin errors++; $display("[TB] FAIL wd_drop_total got %0d expected 0", drop_total); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      trace_valid = 1'b1; trace_data = 36'(i);
      tick();
    end
    trace_valid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL ovf_level got %0d expected 4", level); end
    checks++; if (drop_total !== 16'd2) begin errors++; $display("[TB] FAIL ovf_drop_total got %0d expected 2", drop_total); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 36'(i)) begin errors++; $display("[TB] FAIL ovf_drain%0d got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 36'(i)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("[TB] FAIL ovf_empty got v=%b level=%0d expected v=0 level=0", out_valid, level); end
    out_ready = 1'b0;
  endtask

  task automatic test_marker();
    logic [35:0] expect_q [5];
    expect_q[0] = 36'h1; expect_q[1] = 36'h2; expect_q[2] = 36'h3; expect_q[3] = 36'h4;
    expect_q[4] = 36'hF_DEAD_0003;
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      trace_valid = 1'b1; trace_data = 36'(i);
      tick();
    end
    trace_valid = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL mk_level got %0d expected 4", level); end
    checks++; if (drop_total !== 16'd3) begin errors++; $display("[TB] FAIL mk_drop_total got %0d expected 3", drop_total); end
    checks++; if (out_data !== expect_q[0]) begin errors++; $display("[TB] FAIL mk_drain0 got %h expected %h", out_data, expect_q[0]); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL mk_level_pop got %0d expected 3", level); end
    tick();
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL mk_level_marker got %0d expected 4", level); end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== expect_q[i]) begin errors++; $display("[TB] FAIL mk_drain%0d got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, expect_q[i]); end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || drop_total !== 16'd3) begin errors++; $display("[TB] FAIL mk_end got v=%b drops=%0d expected v=0 drops=3", out_valid, drop_total); end
    out_ready = 1'b0;
  endtask

  task automatic test_trap_freeze();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      trace_valid = 1'b1; trace_data = 36'(i);
      trap = (i == 3);
      tick();
    end
    trap = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL trap_level got %0d expected 3", level); end
    checks++; if (frozen !== 1'b1) begin errors++; $display("[TB] FAIL trap_frozen got %b expected 1", frozen); end
    trace_data = 36'h4; tick();
    trace_data = 36'h5; tick();
    trace_valid = 1'b0;
    checks++; if (level !== 3'd3 || drop_total !== 16'd2) begin errors++; $display("[TB] FAIL trap_drops got level=%0d drops=%0d expected level=3 drops=2", level, drop_total); end
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 36'(i)) begin errors++; $display("[TB] FAIL trap_drain%0d got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 36'(i)); end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || frozen !== 1'b1) begin errors++; $display("[TB] FAIL trap_end got v=%b frozen=%b expected v=0 frozen=1", out_valid, frozen); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      trace_valid = 1'b1; trace_data = 36'h11 + 36'(i);
      tick();
    end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL b2b_full got %0d expected 4", level); end
    trace_data = 36'h15; out_ready = 1'b1;
    tick();
    trace_valid = 1'b0; out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL b2b_level got %0d expected 3", level); end
    checks++; if (drop_total !== 16'd1) begin errors++; $display("[TB] FAIL b2b_drop_total got %0d expected 1", drop_total); end
    checks++; if (out_data !== 36'h12) begin errors++; $display("[TB] FAIL b2b_head got %h expected 12", out_data); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      trace_valid = 1'b1; trace_data = 36'h20 + 36'(i);
      trap = (i == 3);
      tick();
    end
    trap = 1'b0;
    trace_data = 36'h24; tick();
    trace_valid = 1'b0;
    checks++; if (level !== 3'd3 || frozen !== 1'b1 || drop_total !== 16'd1) begin errors++; $display("[TB] FAIL mr_pre got level=%0d frozen=%b drops=%0d expected 3 1 1", level, frozen, drop_total); end
    out_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mr_clear got level=%0d v=%b expected 0 0", level, out_valid); end
    checks++; if (drop_total !== 16'd0 || frozen !== 1'b0) begin errors++; $display("[TB] FAIL mr_status got drops=%0d frozen=%b expected 0 0", drop_total, frozen); end
    trace_valid = 1'b1; trace_data = 36'h0_ABCD_0001;
    tick();
    trace_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 36'h0_ABCD_0001 || level !== 3'd1) begin errors++; $display("[TB] FAIL mr_push got v=%b d=%h level=%0d expected 1 0abcd0001 1", out_valid, out_data, level); end
  endtask

  initial begin
    $display("[TB] trace_capture_fifo bench start");
    test_reset();
    test_write_drain();
`ifdef TRACE_DROP_MARKER_EN
    test_marker();
`else
    test_overflow();
`endif
    test_trap_freeze();
    test_back_to_back_full();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_capture_fifo.md
# trace_capture_fifo

Capture buffer sitting directly downstream of the PicoRV32 core's trace port. It accepts one 36-bit trace word per cycle on `trace_valid`/`trace_data` and buffers it in a FIFO. The buffer is drained over a valid/ready stream to a log writer or debug link. Overflow is counted, and capture freezes once the core traps, so that the tail of execution is preserved.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, ≥ 2.
- `DATA_W`, 36: trace word width; fixed by the core's trace format.
- `clk` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `trace_valid` input 1: trace word present this cycle; no backpressure to the core.
- `trace_data` input DATA_W: `[35:32]` flags, `[31:0]` payload.
- `trap` input 1: core trap indication; level-sensitive.
- `out_valid` output 1: `out_data` holds the FIFO head.
- `out_ready` input 1: consumer accepts the head this cycle.
- `out_data` output DATA_W: FIFO head word.
- `level` output $clog2(DEPTH+1): current occupancy.
- `drop_total` output 16: words dropped since reset; saturates at 16'hFFFF.
- `frozen` output 1: capture stopped after a trap.

## Operation
- Push: `trace_valid` high while in CAPTURE and `level < DEPTH` → word written.
- Full is evaluated on the registered `level` only; a same-cycle pop does not make room for a push.
- Drop: `trace_valid` high while full, or while in DROPPING, or while in FROZEN → word discarded and `drop_total` incremented (saturating).
- Pop: `out_valid && out_ready` → head removed. Simultaneous push and pop leave `level` unchanged.
- Pointers wrap modulo DEPTH.
- States (encoding is in the package):
  - CAPTURE: normal operation.
  - DROPPING: only with the macro enabled; see Configuration.
  - FROZEN: entered the cycle after `trap` is sampled high, from any state.
    - A `trace_valid` word in the same cycle as the first `trap` is still handled by the current state's rules.
    - FROZEN exits only on `reset`.
    - Draining continues while FROZEN.
- Reset: `level`=0, `out_valid`=0, `out_data`=0, `drop_total`=0, `frozen`=0, state=CAPTURE, pending count=0. FIFO contents are discarded, and a reset mid-drain drops `out_valid` on the next cycle.

## Timing
- Push-to-visible latency: a word pushed at edge N appears as `out_valid=1` with valid `out_data` after edge N, i.e. usable in cycle N+1 (show-ahead, registered).
- `out_data` is stable while `out_valid && !out_ready`.
- `level` and `drop_total` update on the edge that performs the push, pop or drop.
- `frozen` rises one cycle after `trap` is first sampled high.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `TRACE_DROP_MARKER_EN` defined:
  - The first drop in CAPTURE moves the state to DROPPING and sets `pending` to 1.
  - In DROPPING, each further dropped word increments `pending` (16-bit, saturating).
  - On the first cycle in DROPPING with `level < DEPTH`, a marker is pushed instead of trace data:
    - `[35:32]` = 4'hF (flag combination never produced by the core);
    - `[31:16]` = 16'hDEAD;
    - `[15:0]` = `pending`.
  - Marker cycle, no concurrent `trace_valid`: `pending` := 0, state → CAPTURE.
  - Marker cycle, concurrent `trace_valid`: that word is dropped, `pending` := 1, state stays DROPPING.
  - In FROZEN with `pending != 0`: one marker is pushed when space is available, then no further pushes.
- `TRACE_DROP_MARKER_EN` not defined:
  - No DROPPING state and no markers.
  - Drops are counted only in `drop_total`.

## Structure
- `trace_capture_pkg` holds:
  - the state enum;
  - `MARKER_TAG` = 4'hF;
  - `MARKER_SIG` = 16'hDEAD;
  - `TRACE_W` = 36.
- Sub-module `trace_sync_fifo`: storage, pointers, `level`, show-ahead output register; push/pop inputs only.
- Top level holds the state machine, drop accounting and marker mux.

## Test plan
All scenarios use DEPTH=4.
- Write / drain: push 3 words 36'h0_0000_0001..3 with `out_ready`=1 → same words out in order, each one cycle after its push; `level` peaks at 1; `drop_total`=0.
- Overflow, macro off: `out_ready`=0, push 6 words → `level`=4, `drop_total`=2; draining yields words 1..4.
- Marker, macro on: `out_ready`=0, push 7 words; raise `out_ready` for 1 cycle with `trace_valid`=0 → a marker 36'hF_DEAD_0003 is pushed; drain order is words 1..4 then the marker.
- Trap freeze: push 2 words, raise `trap` with a third word in the same cycle → 3 words captured; `frozen`=1 next cycle; further pushes increment `drop_total`; full drain yields 3 words.
- Simultaneous push/pop at full: `level`=4, `trace_valid` and `out_ready` both high → pop occurs, push is dropped; `level`=3; `drop_total`+1.
- Mid-operation reset: `level`=3, assert `reset` 1 cycle → `level`=0, `out_valid`=0, `drop_total`=0, `frozen`=0; next push is visible one cycle later.
